// File: rtl/a2d_sched_pkg.sv
// Shared types and channel map for the A2D round-robin scheduler.
// Optional transaction timeout is enabled by defining A2D_SCHED_TMO_EN.
package a2d_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StGap,
        StRead
    } state_e;

    localparam logic [2:0] CH_LFT   = 3'd0;
    localparam logic [2:0] CH_RGHT  = 3'd4;
    localparam logic [2:0] CH_STEER = 3'd5;
    localparam logic [2:0] CH_BATT  = 3'd6;

    // Command word for the channel selected by the round-robin pointer.
    function automatic logic [15:0] build_cmd(input logic [1:0] sel);
        logic [2:0] ch;
        case (sel)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            default: ch = CH_BATT;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

endpackage

// File: rtl/a2d_cyc_cnt.sv
// 10-bit clear/enable cycle counter with terminal-count compare.
// Shared by gap timing and the optional A2D_SCHED_TMO_EN timeout.
module a2d_cyc_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [9:0] tc,
    output logic       hit
);

    logic [9:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 10'd1;
        end
    end

    assign hit = (cnt_q == tc);

endmodule

// File: rtl/a2d_sched.sv
// Round-robin conversion scheduler for the shared SPI A2D converter.
// Define A2D_SCHED_TMO_EN to compile in the per-transaction spi_done timeout.
module a2d_sched
    import a2d_sched_pkg::*;
#(
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned TMO_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        round_done,
    output logic        tmo_err
);

    localparam logic [9:0] GAP_TC = 10'(GAP_CYC - 1);
    localparam logic [9:0] TMO_TC = 10'(TMO_CYC - 1);

    state_e      state_q;
    logic [1:0]  ptr_q;
    logic [11:0] res_q [4];
    logic        cnt_clr;
    logic        cnt_en;
    logic        cnt_hit;
    logic [9:0]  cnt_tc;
    logic [3:0]  unused_rd_hi;

    assign unused_rd_hi = spi_rd[15:12];

    assign lft_ld    = res_q[0];
    assign rght_ld   = res_q[1];
    assign steer_pot = res_q[2];
    assign batt      = res_q[3];

    // Counter restarts on every spi_wrt so it measures both the gap and transaction age.
    assign cnt_clr = (state_q == StIdle) ||
                     (state_q == StCmd && spi_done) ||
                     (state_q == StGap && cnt_hit);
    assign cnt_tc  = (state_q == StGap) ? GAP_TC : TMO_TC;

`ifdef A2D_SCHED_TMO_EN
    logic tmo_q;
    assign tmo_err = tmo_q;
    assign cnt_en  = 1'b1;
`else
    assign tmo_err = 1'b0;
    assign cnt_en  = (state_q == StGap);
`endif

    a2d_cyc_cnt u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc),
        .hit   (cnt_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            spi_cmd    <= '0;
            spi_wrt    <= 1'b0;
            busy       <= 1'b0;
            round_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= '0;
            end
`ifdef A2D_SCHED_TMO_EN
            tmo_q      <= 1'b0;
`endif
        end else begin
            spi_wrt    <= 1'b0;
            round_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (nxt) begin
                        spi_cmd <= build_cmd(ptr_q);
                        spi_wrt <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= StCmd;
                    end
                end
                StCmd: begin
                    if (spi_done) begin
                        state_q <= StGap;
`ifdef A2D_SCHED_TMO_EN
                    end else if (cnt_hit) begin
                        tmo_q      <= 1'b1;
                        ptr_q      <= ptr_q + 2'd1;
                        round_done <= (ptr_q == 2'd3);
                        busy       <= 1'b0;
                        state_q    <= StIdle;
`endif
                    end
                end
                StGap: begin
                    if (cnt_hit) begin
                        spi_wrt <= 1'b1;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    if (spi_done) begin
                        res_q[ptr_q] <= spi_rd[11:0];
                        ptr_q        <= ptr_q + 2'd1;
                        round_done   <= (ptr_q == 2'd3);
                        busy         <= 1'b0;
                        state_q      <= StIdle;
`ifdef A2D_SCHED_TMO_EN
                    end else if (cnt_hit) begin
                        tmo_q      <= 1'b1;
                        ptr_q      <= ptr_q + 2'd1;
                        round_done <= (ptr_q == 2'd3);
                        busy       <= 1'b0;
                        state_q    <= StIdle;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
